// File: rtl/serial_pe_feeder_if.sv
// serial_pe_feeder_if
//   Bundles the two 1-cycle-latency buffer read ports (neuron, weight) and
//   the operand/control bus toward the serial PE.
//   master : the feeder (drives read strobes/addresses and PE operands)
//   slave  : buffers + PE side (returns read data, consumes PE operands)
//   Signals: n_rd_en/n_addr/n_rdata, w_rd_en/w_addr/w_rdata,
//            pe_neuron/pe_weight (16b), pe_ctl (2b), pe_vld.
interface serial_pe_feeder_if #(
  parameter int ADDR_W = 16
);
  logic              n_rd_en;
  logic [ADDR_W-1:0] n_addr;
  logic [15:0]       n_rdata;
  logic              w_rd_en;
  logic [ADDR_W-1:0] w_addr;
  logic [15:0]       w_rdata;
  logic [15:0]       pe_neuron;
  logic [15:0]       pe_weight;
  logic [1:0]        pe_ctl;
  logic              pe_vld;

  modport master (
    output n_rd_en, n_addr, w_rd_en, w_addr,
    output pe_neuron, pe_weight, pe_ctl, pe_vld,
    input  n_rdata, w_rdata
  );

  modport slave (
    input  n_rd_en, n_addr, w_rd_en, w_addr,
    input  pe_neuron, pe_weight, pe_ctl, pe_vld,
    output n_rdata, w_rdata
  );
endinterface

// File: rtl/serial_pe_feeder.sv
// serial_pe_feeder
//   Operand sequencer upstream of the serial PE. A start launches out_num
//   dot products of vec_len elements; one neuron/weight pair is read per
//   non-stalled cycle and forwarded to the PE with first/last flags that
//   line up with the returned buffer data. done pulses when the PE result
//   is valid.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   i_start         : job launch (ignored unless idle)
//   i_vec_len       : elements per dot product (latched)
//   i_out_num       : number of dot products (latched)
//   i_n_base/i_w_base : neuron / weight base addresses (latched)
//   i_stall         : suppresses the read in the current issue cycle
//   bus             : buffer read ports and PE operand bus (master side)
//   o_busy, o_done, o_err : job status
// Configuration macro:
//   SERIAL_PE_FEED_ERR_EN : when defined, a zero-length start pulses o_err
//                           together with o_done; otherwise o_err is 0.
module serial_pe_feeder #(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 10,
  parameter int OUT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [LEN_W-1:0]  i_vec_len,
  input  logic [OUT_W-1:0]  i_out_num,
  input  logic [ADDR_W-1:0] i_n_base,
  input  logic [ADDR_W-1:0] i_w_base,
  input  logic              i_stall,
  serial_pe_feeder_if.master bus,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0]  LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [OUT_W-1:0]  OUT_ONE  = {{(OUT_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_issue;
  logic              w_zero_len;
  logic              w_accept;
  logic              w_first_i;
  logic              w_last_i;
  logic              w_last_o;

  logic [LEN_W-1:0]  r_len;
  logic [OUT_W-1:0]  r_num;
  logic [ADDR_W-1:0] r_n_base;
  logic [ADDR_W-1:0] r_n_ptr;
  logic [ADDR_W-1:0] r_w_ptr;
  logic [LEN_W-1:0]  r_i;
  logic [OUT_W-1:0]  r_o;
  logic              r_pe_vld;
  logic [1:0]        r_pe_ctl;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  assign w_zero_len = (i_vec_len == {LEN_W{1'b0}}) || (i_out_num == {OUT_W{1'b0}});
  assign w_accept   = (r_state == ST_IDLE) && i_start && !w_zero_len;
  assign w_first_i  = (r_i == {LEN_W{1'b0}});
  assign w_last_i   = (r_i == (r_len - LEN_ONE));
  assign w_last_o   = (r_o == (r_num - OUT_ONE));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and read-strobe generation; stall only gates the issue cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = w_zero_len ? ST_FIN : ST_ISSUE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (!i_stall) begin
          w_issue = 1'b1;
          if (w_last_i && w_last_o) begin
            w_state_nxt = ST_DRAIN;
          end else begin
            w_state_nxt = ST_ISSUE;
          end
        end else begin
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_DRAIN: w_state_nxt = ST_FIN;
      ST_FIN:   w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Job parameters, element/output counters and running address pointers.
  // The neuron pointer rewinds to the base at each row end; the weight
  // pointer never rewinds, so rows are contiguous without a multiplier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len    <= {LEN_W{1'b0}};
      r_num    <= {OUT_W{1'b0}};
      r_n_base <= {ADDR_W{1'b0}};
      r_n_ptr  <= {ADDR_W{1'b0}};
      r_w_ptr  <= {ADDR_W{1'b0}};
      r_i      <= {LEN_W{1'b0}};
      r_o      <= {OUT_W{1'b0}};
    end else if (w_accept) begin
      r_len    <= i_vec_len;
      r_num    <= i_out_num;
      r_n_base <= i_n_base;
      r_n_ptr  <= i_n_base;
      r_w_ptr  <= i_w_base;
      r_i      <= {LEN_W{1'b0}};
      r_o      <= {OUT_W{1'b0}};
    end else if (w_issue) begin
      r_w_ptr <= r_w_ptr + ADDR_ONE;
      if (w_last_i) begin
        r_i     <= {LEN_W{1'b0}};
        r_n_ptr <= r_n_base;
        r_o     <= r_o + OUT_ONE;
      end else begin
        r_i     <= r_i + LEN_ONE;
        r_n_ptr <= r_n_ptr + ADDR_ONE;
      end
    end else begin
      r_i <= r_i;
    end
  end

  // PE qualifiers are delayed one cycle to align with buffer read data;
  // status flags are registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pe_vld <= 1'b0;
      r_pe_ctl <= 2'b00;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_pe_vld <= w_issue;
      r_pe_ctl <= w_issue ? {w_last_i, w_first_i} : 2'b00;
      r_busy   <= (w_state_nxt != ST_IDLE);
      r_done   <= (w_state_nxt == ST_FIN);
`ifdef SERIAL_PE_FEED_ERR_EN
      // FIN reached straight from IDLE only for a zero-length start.
      r_err    <= (r_state == ST_IDLE) && (w_state_nxt == ST_FIN);
`else
      r_err    <= 1'b0;
`endif
    end
  end

  assign bus.n_rd_en   = w_issue;
  assign bus.w_rd_en   = w_issue;
  assign bus.n_addr    = w_issue ? r_n_ptr : {ADDR_W{1'b0}};
  assign bus.w_addr    = w_issue ? r_w_ptr : {ADDR_W{1'b0}};
  assign bus.pe_neuron = bus.n_rdata;
  assign bus.pe_weight = bus.w_rdata;
  assign bus.pe_vld    = r_pe_vld;
  assign bus.pe_ctl    = r_pe_ctl;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_err         = r_err;

endmodule

// File: tb/tb_serial_pe_feeder.sv
// tb_serial_pe_feeder
//   Directed test of serial_pe_feeder: buffer models answer reads one cycle
//   later, a small PE model accumulates the operand stream, and per-cycle
//   strobe/valid/status masks plus address, control and result lists are
//   compared against hand-derived expectations.
module tb_serial_pe_feeder;
  localparam int ADDR_W = 16;
  localparam int LEN_W  = 10;
  localparam int OUT_W  = 8;
`ifdef SERIAL_PE_FEED_ERR_EN
  localparam logic [31:0] ZERR = 32'h2;
`else
  localparam logic [31:0] ZERR = 32'h0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic stall = 1'b0;
  logic [LEN_W-1:0]  vec_len = '0;
  logic [OUT_W-1:0]  out_num = '0;
  logic [ADDR_W-1:0] n_base = '0;
  logic [ADDR_W-1:0] w_base = '0;
  logic busy, done, err;

  always #5 clk = ~clk;

  serial_pe_feeder_if #(.ADDR_W(ADDR_W)) bus ();

  serial_pe_feeder #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_vec_len(vec_len),
    .i_out_num(out_num), .i_n_base(n_base), .i_w_base(w_base),
    .i_stall(stall), .bus(bus), .o_busy(busy), .o_done(done), .o_err(err)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] nd(input logic [15:0] a);
    return a * 16'd3 + 16'd1;
  endfunction

  function automatic logic [15:0] wd(input logic [15:0] a);
    return a ^ 16'h00A5;
  endfunction

  function automatic logic [31:0] dot(input logic [15:0] nb, input logic [15:0] wb, input int len);
    logic [31:0] s = 32'd0;
    for (int j = 0; j < len; j++)
      s += {16'd0, nd(nb + 16'(j))} * {16'd0, wd(wb + 16'(j))};
    return s;
  endfunction

  // Buffer models: one-cycle read latency.
  always @(posedge clk) begin
    if (bus.n_rd_en) bus.n_rdata <= nd(bus.n_addr);
    if (bus.w_rd_en) bus.w_rdata <= wd(bus.w_addr);
  end

  logic [31:0] m_rd, m_wrd, m_vld, m_done, m_busy, m_err;
  logic [15:0] q_naddr[$], q_waddr[$], e_naddr[$], e_waddr[$];
  logic [1:0]  q_ctl[$], e_ctl[$];
  logic [31:0] q_res[$], e_res[$];
  logic [31:0] acc;

  task automatic run_job(input logic [LEN_W-1:0] len, input logic [OUT_W-1:0] num,
                         input logic [15:0] nb, input logic [15:0] wb,
                         input logic [31:0] stall_m, input logic [31:0] start_m, input int ncyc);
    m_rd = '0; m_wrd = '0; m_vld = '0; m_done = '0; m_busy = '0; m_err = '0;
    q_naddr.delete(); q_waddr.delete(); q_ctl.delete(); q_res.delete();
    acc = 32'd0;
    @(posedge clk); #1;
    vec_len = len; out_num = num; n_base = nb; w_base = wb;
    start = 1'b1; stall = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge clk); #1;
      start = start_m[k];
      stall = stall_m[k];
      @(negedge clk);
      m_rd[k] = bus.n_rd_en; m_wrd[k] = bus.w_rd_en; m_vld[k] = bus.pe_vld;
      m_done[k] = done; m_busy[k] = busy; m_err[k] = err;
      if (bus.n_rd_en) q_naddr.push_back(bus.n_addr);
      if (bus.w_rd_en) q_waddr.push_back(bus.w_addr);
      if (bus.pe_vld) begin
        q_ctl.push_back(bus.pe_ctl);
        if (bus.pe_ctl[0]) acc = 32'd0;
        acc += {16'd0, bus.pe_neuron} * {16'd0, bus.pe_weight};
        if (bus.pe_ctl[1]) q_res.push_back(acc);
      end else begin
        if (bus.pe_ctl != 2'b00) q_ctl.push_back(bus.pe_ctl);
      end
    end
    start = 1'b0; stall = 1'b0;
  endtask

  task automatic check_job(input string nm, input logic [31:0] rd, input logic [31:0] vld,
                           input logic [31:0] dn, input logic [31:0] bsy, input logic [31:0] er);
    check_val({nm, "_n_rd_en"}, 40'(m_rd), 40'(rd));
    check_val({nm, "_w_rd_en"}, 40'(m_wrd), 40'(rd));
    check_val({nm, "_pe_vld"}, 40'(m_vld), 40'(vld));
    check_val({nm, "_done"}, 40'(m_done), 40'(dn));
    check_val({nm, "_busy"}, 40'(m_busy), 40'(bsy));
    check_val({nm, "_err"}, 40'(m_err), 40'(er));
    check_val({nm, "_n_cnt"}, 40'(q_naddr.size()), 40'(e_naddr.size()));
    check_val({nm, "_w_cnt"}, 40'(q_waddr.size()), 40'(e_waddr.size()));
    check_val({nm, "_ctl_cnt"}, 40'(q_ctl.size()), 40'(e_ctl.size()));
    check_val({nm, "_res_cnt"}, 40'(q_res.size()), 40'(e_res.size()));
    for (int j = 0; j < e_naddr.size() && j < q_naddr.size(); j++)
      check_val($sformatf("%s_n_addr%0d", nm, j), 40'(q_naddr[j]), 40'(e_naddr[j]));
    for (int j = 0; j < e_waddr.size() && j < q_waddr.size(); j++)
      check_val($sformatf("%s_w_addr%0d", nm, j), 40'(q_waddr[j]), 40'(e_waddr[j]));
    for (int j = 0; j < e_ctl.size() && j < q_ctl.size(); j++)
      check_val($sformatf("%s_ctl%0d", nm, j), 40'(q_ctl[j]), 40'(e_ctl[j]));
    for (int j = 0; j < e_res.size() && j < q_res.size(); j++)
      check_val($sformatf("%s_res%0d", nm, j), 40'(q_res[j]), 40'(e_res[j]));
  endtask

  initial begin
    #23;
    check_val("reset_ctrl", 40'({bus.n_rd_en, bus.w_rd_en, bus.pe_vld, bus.pe_ctl, busy, done, err}), 40'd0);
    check_val("reset_addr", 40'({bus.n_addr, bus.w_addr}), 40'd0);
    rst_n = 1'b1;

    // vec_len 4, out_num 1, no stall
    e_naddr = '{16'h10, 16'h11, 16'h12, 16'h13};
    e_waddr = '{16'h80, 16'h81, 16'h82, 16'h83};
    e_ctl = '{2'b01, 2'b00, 2'b00, 2'b10};
    e_res = '{dot(16'h10, 16'h80, 4)};
    run_job(10'd4, 8'd1, 16'h10, 16'h80, 32'h0, 32'h0, 8);
    check_job("t1", 32'h1E, 32'h3C, 32'h40, 32'h7E, 32'h0);

    // vec_len 3, out_num 2: no bubble across rows
    e_naddr = '{16'h0, 16'h1, 16'h2, 16'h0, 16'h1, 16'h2};
    e_waddr = '{16'h20, 16'h21, 16'h22, 16'h23, 16'h24, 16'h25};
    e_ctl = '{2'b01, 2'b00, 2'b10, 2'b01, 2'b00, 2'b10};
    e_res = '{dot(16'h0, 16'h20, 3), dot(16'h0, 16'h23, 3)};
    run_job(10'd3, 8'd2, 16'h0, 16'h20, 32'h0, 32'h0, 10);
    check_job("t2", 32'h7E, 32'hFC, 32'h100, 32'h1FE, 32'h0);

    // vec_len 1, out_num 3: every element is first and last
    e_naddr = '{16'h40, 16'h40, 16'h40};
    e_waddr = '{16'h50, 16'h51, 16'h52};
    e_ctl = '{2'b11, 2'b11, 2'b11};
    e_res = '{dot(16'h40, 16'h50, 1), dot(16'h40, 16'h51, 1), dot(16'h40, 16'h52, 1)};
    run_job(10'd1, 8'd3, 16'h40, 16'h50, 32'h0, 32'h0, 7);
    check_job("t3", 32'h0E, 32'h1C, 32'h20, 32'h3E, 32'h0);

    // stall in C+2, C+3 and a start pulse in C+3 that must be ignored
    e_naddr = '{16'h10, 16'h11, 16'h12, 16'h13};
    e_waddr = '{16'h80, 16'h81, 16'h82, 16'h83};
    e_ctl = '{2'b01, 2'b00, 2'b00, 2'b10};
    e_res = '{dot(16'h10, 16'h80, 4)};
    run_job(10'd4, 8'd1, 16'h10, 16'h80, 32'h0C, 32'h08, 10);
    check_job("t4", 32'h72, 32'hE4, 32'h100, 32'h1FE, 32'h0);

    // zero-length jobs
    e_naddr.delete(); e_waddr.delete(); e_ctl.delete(); e_res.delete();
    run_job(10'd0, 8'd5, 16'h10, 16'h80, 32'h0, 32'h0, 4);
    check_job("t5", 32'h0, 32'h0, 32'h2, 32'h2, ZERR);
    run_job(10'd2, 8'd0, 16'h10, 16'h80, 32'h0, 32'h0, 4);
    check_job("t6", 32'h0, 32'h0, 32'h2, 32'h2, ZERR);

    // address wrap modulo 2^16
    e_naddr = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    e_waddr = '{16'hFFFF, 16'h0000, 16'h0001, 16'h0002};
    e_ctl = '{2'b01, 2'b00, 2'b00, 2'b10};
    e_res = '{dot(16'hFFFE, 16'hFFFF, 4)};
    run_job(10'd4, 8'd1, 16'hFFFE, 16'hFFFF, 32'h0, 32'h0, 8);
    check_job("t7", 32'h1E, 32'h3C, 32'h40, 32'h7E, 32'h0);

    // asynchronous reset mid-ISSUE
    @(posedge clk); #1;
    vec_len = 10'd4; out_num = 8'd2; n_base = 16'h30; w_base = 16'h60; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #3;
    check_val("pre_rst_rd", 40'(bus.n_rd_en), 40'd1);
    rst_n = 1'b0;
    #1;
    check_val("rst_ctrl", 40'({bus.n_rd_en, bus.w_rd_en, bus.pe_vld, bus.pe_ctl, busy, done, err}), 40'd0);
    check_val("rst_addr", 40'({bus.n_addr, bus.w_addr}), 40'd0);
    #10;
    rst_n = 1'b1;

    e_naddr = '{16'h10, 16'h11, 16'h12, 16'h13};
    e_waddr = '{16'h80, 16'h81, 16'h82, 16'h83};
    e_ctl = '{2'b01, 2'b00, 2'b00, 2'b10};
    e_res = '{dot(16'h10, 16'h80, 4)};
    run_job(10'd4, 8'd1, 16'h10, 16'h80, 32'h0, 32'h0, 8);
    check_job("t8", 32'h1E, 32'h3C, 32'h40, 32'h7E, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
